// File: rtl/sender_arb_if.sv
// -----------------------------------------------------------------------------
// sender_arb_if
// Purpose : Groups the byte handshakes around the UART sender arbiter.
//           It carries two request ports, the commit path (port 0) and the
//           monitor/debug path (port 1), plus the single output toward the
//           UART sender.
// Signals : req0_valid/req0_data/req0_ready  - commit-path byte handshake
//           req1_valid/req1_data/req1_ready  - monitor byte handshake
//           sender_ready                     - UART sender can take a byte
//           sender_valid/sender_in/owner     - registered byte toward sender
// Modports: master - byte producers and the UART sender (drive valids/data
//                    and sender_ready)
//           slave  - the arbiter itself
// -----------------------------------------------------------------------------
interface sender_arb_if;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic       sender_ready;
  logic       sender_valid;
  logic [7:0] sender_in;
  logic       owner;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, sender_ready,
    input  req0_ready, req1_ready, sender_valid, sender_in, owner
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, sender_ready,
    output req0_ready, req1_ready, sender_valid, sender_in, owner
  );
endinterface : sender_arb_if

// File: rtl/sender_arb.sv
// -----------------------------------------------------------------------------
// sender_arb
// Purpose : Merges two byte streams into one UART sender through a one-byte
//           hold register. When both ports request, port 0 (commit path) has
//           priority, but it may win at most MAX_BURST times in a row while
//           port 1 is waiting. After that, port 1 gets one grant.
//           A new byte is accepted whenever the hold register is empty or is
//           being drained this cycle, so throughput is one byte per cycle.
// Ports   : clk   - single clock, all state updates on posedge
//           reset - synchronous, active-high; discards any held byte
//           bus   - sender_arb_if.slave (request ports and sender side)
// Params  : MAX_BURST - max consecutive port-0 grants while port 1 waits
//                       (1..255)
// Config  : SENDER_ARB_RR_EN - when defined, contention is resolved by plain
//           round-robin using a last-granted flag. MAX_BURST is then unused.
// -----------------------------------------------------------------------------
module sender_arb #(
  parameter int unsigned MAX_BURST = 8
) (
  input  logic          clk,
  input  logic          reset,
  sender_arb_if.slave   bus
);

  logic       w_load;
  logic       w_grant0;
  logic       w_grant1;
  logic       w_acc0;
  logic       w_acc1;

  logic       r_hold_valid;
  logic       r_hold_src;
  logic [7:0] r_hold_data;

`ifdef SENDER_ARB_RR_EN
  logic       r_last;       // 1 = port 1 was granted last
`else
  localparam int unsigned CW = $clog2(MAX_BURST + 1);
  logic [CW-1:0] r_burst_cnt;
`endif

  // NOTE: every always_comb output is assigned on every path; otherwise a
  // latch is inferred.
  always_comb begin
    // The register can take a byte when it is empty or drains this cycle.
    w_load = !r_hold_valid || bus.sender_ready;
`ifdef SENDER_ARB_RR_EN
    w_grant1 = bus.req1_valid && (!bus.req0_valid || !r_last);
`else
    w_grant1 = bus.req1_valid &&
               (!bus.req0_valid || (r_burst_cnt == CW'(MAX_BURST)));
`endif
    w_grant0 = bus.req0_valid && !w_grant1;
    // Gate with reset so nothing is accepted during a cycle in which reset
    // is high. Such a byte would be lost when the hold register clears.
    w_acc0   = w_load && w_grant0 && !reset;
    w_acc1   = w_load && w_grant1 && !reset;
  end

  assign bus.req0_ready   = w_acc0;
  assign bus.req1_ready   = w_acc1;
  assign bus.sender_valid = r_hold_valid;
  assign bus.sender_in    = r_hold_data;
  assign bus.owner        = r_hold_src;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold_valid <= 1'b0;
      r_hold_src   <= 1'b0;
`ifdef SENDER_ARB_RR_EN
      r_last       <= 1'b0;
`else
      r_burst_cnt  <= '0;
`endif
    end else begin
      if (w_acc0 || w_acc1) begin
        r_hold_valid <= 1'b1;
        r_hold_src   <= w_acc1;
      end else if (bus.sender_ready) begin
        r_hold_valid <= 1'b0;
      end

`ifdef SENDER_ARB_RR_EN
      if (w_acc1) begin
        r_last <= 1'b1;
      end else if (w_acc0) begin
        r_last <= 1'b0;
      end
`else
      // The count is the number of port-0 wins since port 1 started waiting.
      if (w_acc1 || !bus.req1_valid) begin
        r_burst_cnt <= '0;
      end else if (w_acc0 && (r_burst_cnt != CW'(MAX_BURST))) begin
        r_burst_cnt <= r_burst_cnt + CW'(1);
      end
`endif
    end
  end

  // NOTE: the data register has no reset. hold_valid qualifies it, so
  // resetting it would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (w_acc0) begin
      r_hold_data <= bus.req0_data;
    end else if (w_acc1) begin
      r_hold_data <= bus.req1_data;
    end
  end

endmodule : sender_arb

// File: doc/sender_arb.md
SENDER_ARB -- requirements
Module: sender_arb

Interface
REQ-001 SHALL have parameter MAX_BURST, default 8, meaning the maximum number of consecutive port-0 grants while port 1 is waiting; legal range 1..255.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req0_valid  input  1  commit-path (program output) byte valid.
REQ-005 SHALL have port req0_data  input  8  commit-path byte.
REQ-006 SHALL have port req0_ready  output  1  commit-path byte accepted this cycle.
REQ-007 SHALL have port req1_valid  input  1  monitor/debug byte valid.
REQ-008 SHALL have port req1_data  input  8  monitor/debug byte.
REQ-009 SHALL have port req1_ready  output  1  monitor byte accepted this cycle.
REQ-010 SHALL have port sender_ready  input  1  UART sender can take a byte.
REQ-011 SHALL have port sender_valid  output  1  registered byte valid toward the sender.
REQ-012 SHALL have port sender_in  output  8  registered byte toward the sender.
REQ-013 SHALL have port owner  output  1  source of the byte in the hold register (0 = commit path, 1 = monitor).

Function
REQ-014 SHALL hold one byte in a hold register (hold_valid, hold_data, hold_src); sender_valid = hold_valid, sender_in = hold_data, owner = hold_src.
REQ-015 SHALL compute load = !hold_valid || sender_ready; a new byte is accepted only when load is 1.
REQ-016 SHALL drive req0_ready = load && grant0 and req1_ready = load && grant1, with grant0 and grant1 mutually exclusive and each granted port's valid high.
REQ-017 SHALL grant the only requesting port when exactly one of req0_valid and req1_valid is high.
REQ-018 SHALL, when both ports request, grant port 0 unless burst_cnt == MAX_BURST, in which case it grants port 1.
REQ-019 SHALL define burst_cnt as a $clog2(MAX_BURST+1)-bit counter with these updates, in priority order:
- clear to 0 on a port-1 acceptance, or when req1_valid is low;
- otherwise increment on a port-0 acceptance while req1_valid is high, saturating at MAX_BURST.
REQ-020 SHALL, on acceptance, load the granted byte into the hold register on the next edge, giving 1-cycle latency from accept to sender_valid.
REQ-021 SHALL, when sender_ready and no acceptance occur in the same cycle, clear hold_valid.
REQ-022 SHALL, when sender_ready and an acceptance occur in the same cycle, replace the hold register back-to-back, sustaining 1 byte per cycle.
REQ-023 SHALL keep hold_data and hold_src stable while hold_valid && !sender_ready.
REQ-024 SHALL never drop or duplicate a byte; per-port byte order is preserved.
REQ-025 SHALL make req*_ready independent of sender_ready whenever hold_valid = 0.

Reset
REQ-026 SHALL, while reset is 1 at a clock edge, clear hold_valid, burst_cnt and hold_src to 0; hold_data is don't-care.
REQ-027 SHALL drive req0_ready = req1_ready = 0 in any cycle where reset is 1.
REQ-028 SHALL discard a byte held at reset mid-operation without handing it to the sender.

Configuration
REQ-029 SHALL, with SENDER_ARB_RR_EN defined, replace REQ-018/REQ-019 with a 1-bit last-granted flag (reset 0): on contention the port other than the last granted wins; MAX_BURST and burst_cnt are unused.
REQ-030 SHALL, without SENDER_ARB_RR_EN, implement the burst-limited port-0 priority of REQ-018/REQ-019.

Verification
REQ-031 SHALL cover: reset, then req0 bytes 0x41 and 0x42 with sender_ready = 1 -> sender_in = 0x41 then 0x42 on consecutive cycles, owner = 0.
REQ-032 SHALL cover: 0x55 held with sender_ready = 0 for 5 cycles while req0 is valid -> req0_ready = 0 and sender_in = 0x55 throughout; the byte is sent on the first ready cycle.
REQ-033 SHALL cover: MAX_BURST = 3, both ports streaming continuously, sender_ready = 1 -> grant pattern 0,0,0,1,0,0,0,1.
REQ-034 SHALL cover: reset asserted while hold_valid = 1 -> next cycle sender_valid = 0, the held byte is never sent, and both ready outputs are 0 during reset.
REQ-035 SHALL cover: SENDER_ARB_RR_EN defined, both ports streaming -> grants alternate 0,1,0,1 starting with port 1 after reset.
REQ-036 SHALL cover: random valid/ready stimulus for 10k cycles -> the scoreboard shows each port's byte stream delivered complete and in order.
